seq_divider: RTL and testbench

- Multi-cycle unsigned restoring divider; the inverse operation of the team's combinational array multipliers.
- Takes a DW-bit dividend and a VW-bit divisor; returns a DW-bit quotient and a VW-bit remainder.
- Produces one quotient bit per cycle, with valid/ready handshakes on both input and output.
- Used as the reference divide path and for round-trip checks against multiplier outputs (o = x*y; o/y == x, remainder 0).

---
 rtl/div_pkg.sv | 19 +
 rtl/div_step.sv | 21 ++
 rtl/seq_divider.sv | 165 ++++++++++++++++
 tb/tb_seq_divider.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and defaults for the sequential restoring divider.
package div_pkg;

    localparam int unsigned DefDw = 8;
    localparam int unsigned DefVw = 4;

    function automatic int unsigned cnt_width(input int unsigned dw);
        return (dw > 1) ? $clog2(dw) : 1;
    endfunction

    localparam int unsigned DefCntW = cnt_width(DefDw);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial subtract.
module div_step #(
    parameter int unsigned VW = 4
) (
    input  logic [VW:0]   rem_in,
    input  logic          dvd_bit,
    input  logic [VW-1:0] divisor,
    output logic [VW:0]   rem_out,
    output logic          q_bit
);

    logic [VW:0]   shifted;
    logic [VW+1:0] diff;

    // rem_in is always < divisor, so its top bit is zero and the shift cannot overflow
    assign shifted = {rem_in[VW-1:0], dvd_bit};
    assign diff    = {1'b0, shifted} - {2'b00, divisor};
    assign q_bit   = ~diff[VW+1];
    assign rem_out = q_bit ? diff[VW:0] : shifted;

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per cycle, valid/ready on both sides.
// Optional SEQ_DIVIDER_SELFCHECK_EN adds chk_err: quotient*divisor+remainder vs dividend.
module seq_divider
    import div_pkg::*;
#(
    parameter int unsigned DW = DefDw,
    parameter int unsigned VW = DefVw
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          out_valid,
    input  logic          out_ready,
`ifdef SEQ_DIVIDER_SELFCHECK_EN
    output logic          chk_err,
`endif
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_by_zero
);

    localparam int unsigned CntW = cnt_width(DW);

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    // Dividend bits leave at the MSB while quotient bits enter at the LSB
    logic [DW-1:0]   shreg_q, shreg_d;
    logic [VW-1:0]   dvs_q, dvs_d;
    logic [VW:0]     prem_q, prem_d;
    logic [DW-1:0]   quo_q, quo_d;
    logic [VW-1:0]   rem_q, rem_d;
    logic            dbz_q, dbz_d;

    logic [VW:0]     step_rem;
    logic            step_q;
    logic [DW-1:0]   fin_quo;
    logic            last_step;

    div_step #(.VW(VW)) u_step (
        .rem_in  (prem_q),
        .dvd_bit (shreg_q[DW-1]),
        .divisor (dvs_q),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    assign fin_quo   = (shreg_q << 1) | DW'(step_q);
    assign last_step = (state_q == StRun) && (cnt_q == '0);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        dvs_d     = dvs_q;
        prem_d    = prem_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dbz_d     = dbz_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    shreg_d = dividend;
                    dvs_d   = divisor;
                    if (divisor != '0) begin
                        state_d = StRun;
                        cnt_d   = CntW'(DW - 1);
                        prem_d  = '0;
                    end else begin
                        state_d = StDone;
                        quo_d   = '1;
                        rem_d   = '0;
                        dbz_d   = 1'b1;
                    end
                end
            end
            StRun: begin
                shreg_d = fin_quo;
                prem_d  = step_rem;
                cnt_d   = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = StDone;
                    quo_d   = fin_quo;
                    rem_d   = step_rem[VW-1:0];
                    dbz_d   = 1'b0;
                end
            end
            StDone: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            shreg_q <= '0;
            dvs_q   <= '0;
            prem_q  <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            dvs_q   <= dvs_d;
            prem_q  <= prem_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

`ifdef SEQ_DIVIDER_SELFCHECK_EN
    localparam int unsigned PW = DW + VW;

    logic [DW-1:0] dvd_orig_q;
    logic [PW-1:0] chk_prod;
    logic          chk_q, chk_d;

    assign chk_prod = PW'(fin_quo) * PW'(dvs_q) + PW'(step_rem[VW-1:0]);

    always_comb begin
        chk_d = chk_q;
        if (state_q == StIdle) begin
            chk_d = 1'b0;
        end else if (last_step) begin
            chk_d = (chk_prod != PW'(dvd_orig_q));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd_orig_q <= '0;
            chk_q      <= 1'b0;
        end else begin
            if (state_q == StIdle && in_valid) begin
                dvd_orig_q <= dividend;
            end
            chk_q <= chk_d;
        end
    end

    assign chk_err = chk_q;
`else
    logic unused_last_step;
    assign unused_last_step = last_step;
`endif

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: driver pushes expected results, monitor pops on handshake.
module tb_seq_divider;

    localparam int DW = 8;
    localparam int VW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] dividend = '0;
    logic [VW-1:0] divisor = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          div_by_zero;
`ifdef SEQ_DIVIDER_SELFCHECK_EN
    logic          chk_err;
`endif

    seq_divider #(.DW(DW), .VW(VW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
`ifdef SEQ_DIVIDER_SELFCHECK_EN
        .chk_err     (chk_err),
`endif
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] q;
        logic [VW-1:0] r;
        logic          dbz;
        int            acc;
        int            lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;
    bit   seen = 0;
    bit   done_rnd = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference model: plain integer division
    function automatic exp_t model(input int a, input int b, input int acc);
        exp_t e;
        e.acc = acc;
        if (b == 0) begin
            e.q = '1; e.r = '0; e.dbz = 1'b1; e.lat = 0;
        end else begin
            e.q = DW'(a / b); e.r = VW'(a % b); e.dbz = 1'b0; e.lat = DW;
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            seen = 0;
        end else if (out_valid) begin
            if (!seen) begin
                seen = 1;
                if (sb.size() == 0) check("spurious_out_valid", 1, 0);
                else check("latency", cyc - sb[0].acc, sb[0].lat);
            end
            if (out_ready) begin
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    check("quotient", quotient, e.q);
                    check("remainder", remainder, e.r);
                    check("div_by_zero", div_by_zero, e.dbz);
`ifdef SEQ_DIVIDER_SELFCHECK_EN
                    check("chk_err", chk_err, 0);
`endif
                end
                seen = 0;
            end
        end
    end

    task automatic send(input int a, input int b);
        int n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready) check("in_ready_timeout", 0, 1);
        dividend = DW'(a);
        divisor  = VW'(b);
        in_valid = 1'b1;
        @(posedge clk); #1;
        sb.push_back(model(a, b, cyc));
        in_valid = 1'b0;
        // Operands must not be resampled after the accept edge
        dividend = DW'($urandom);
        divisor  = VW'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || !in_ready) && n < 500) begin
            @(posedge clk); #1; n++;
        end
        check("drain_timeout", sb.size(), 0);
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1; n++;
        end
        check("wait_out_valid", out_valid, 1);
    endtask

    initial begin
        #12;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_quotient", quotient, 0);
        check("rst_remainder", remainder, 0);
        check("rst_div_by_zero", div_by_zero, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        send(200, 7);
        send(255, 1);
        send(0, 9);
        send(3, 15);
        send(5, 0);
        drain();

        // Backpressure: result held, in_ready low, stray operands ignored
        out_ready = 1'b0;
        send(100, 3);
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            check("bp_quotient", quotient, 33);
            check("bp_remainder", remainder, 1);
            check("bp_in_ready", in_ready, 0);
            check("bp_out_valid", out_valid, 1);
            if (i == 2) begin
                dividend = 8'd50; divisor = 4'd5; in_valid = 1'b1;
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        send(50, 5);
        drain();

        // Reset mid-RUN drops the in-flight result
        send(200, 7);
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        sb.delete();
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_quotient", quotient, 0);
        check("midrst_remainder", remainder, 0);
        check("midrst_div_by_zero", div_by_zero, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send(17, 4);
        drain();

        // Random operands with random backpressure
        fork
            begin
                for (int k = 0; k < 200; k++) begin
                    send(int'($urandom_range(0, 255)), int'($urandom_range(0, 15)));
                end
                drain();
                done_rnd = 1;
            end
            begin
                while (!done_rnd) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;

        // Exhaustive non-zero divisor sweep
        for (int a = 0; a < 256; a++) begin
            for (int b = 1; b < 16; b++) begin
                send(a, b);
            end
        end
        drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
